// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared constants and types for the 320x240 banked frame memory and the
// blocks that write and read it (upstream writer, memory, raster reader).
//   IMG_W / IMG_H : frame geometry (pixels per line / lines per frame)
//   PIX_W         : pixel width
//   COL_W / ROW_W : address widths derived from the geometry
//   state_t       : raster reader FSM states
//   tagged_pix_t  : pixel word with its stream markers, as held in the
//                   reader's output buffer
// -----------------------------------------------------------------------------
package frame_pkg;

  localparam int IMG_W = 320;
  localparam int IMG_H = 240;
  localparam int PIX_W = 32;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic             eof;
    logic             eol;
    logic             sof;
    logic [PIX_W-1:0] data;
  } tagged_pix_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// -----------------------------------------------------------------------------
// pix_skid_fifo
// Two-entry synchronous FIFO used as the output skid buffer of the raster
// reader. A push into a full FIFO is accepted only together with a pop.
// Storage is not reset; only pointers and occupancy are.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : write request and data
//   pop, dout   : read request and head-of-queue data
//   full, empty : occupancy flags
//   level       : occupancy (0..2), feeds the reader's credit rule
// -----------------------------------------------------------------------------
module pix_skid_fifo #(
  parameter int WIDTH = 35
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign level = count;

endmodule

// File: rtl/frame_raster_reader.sv
// -----------------------------------------------------------------------------
// frame_raster_reader
// Walks the frame memory in raster order after a start pulse and turns the
// 1-cycle-latency read data into a valid/ready pixel stream with SOF/EOL/EOF
// markers. Sustains 1 pixel/cycle and never drops data under backpressure.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : 1-cycle frame start pulse (ignored while busy)
//   busy                : frame in progress
//   rd_en, rd_col/row   : read strobe and address to the frame memory
//   rd_data             : memory data, valid 1 cycle after rd_en
//   pix_data/valid/ready: output pixel stream
//   pix_sof/eol/eof     : stream markers qualifying pix_data
//   frame_done          : 1-cycle pulse once the EOF pixel has left
// -----------------------------------------------------------------------------
module frame_raster_reader #(
  parameter int IMG_W = frame_pkg::IMG_W,
  parameter int IMG_H = frame_pkg::IMG_H,
  parameter int PIX_W = frame_pkg::PIX_W,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             rd_en,
  output logic [COL_W-1:0] rd_col,
  output logic [ROW_W-1:0] rd_row,
  input  logic [PIX_W-1:0] rd_data,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic             frame_done
);

  import frame_pkg::*;

  localparam int               TW       = PIX_W + 3;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  state_t           state_q;
  state_t           state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             inflight_p1;
  logic             sof_p1;
  logic             eol_p1;
  logic             eof_p1;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_level;
  logic [TW-1:0]    fifo_din;
  logic [TW-1:0]    fifo_dout;
  logic [TW-1:0]    head;

  logic             col_last;
  logic             row_last;
  logic             xfer;
  logic [2:0]       credit_used;
  logic             credit_ok;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // When the buffer is empty the returning read word is presented straight
  // away; it is only parked in the FIFO if the consumer does not take it.
  assign pix_valid = !fifo_empty || inflight_p1;
  assign xfer      = pix_valid && pix_ready;
  assign fifo_pop  = !fifo_empty && pix_ready;
  assign fifo_din  = {eof_p1, eol_p1, sof_p1, rd_data};
  assign fifo_push = inflight_p1 && !(fifo_empty && pix_ready) &&
                     (!fifo_full || fifo_pop);
  assign head      = fifo_empty ? fifo_din : fifo_dout;

  assign {pix_eof, pix_eol, pix_sof, pix_data} = pix_valid ? head : '0;

  // Words held or on their way must leave room for one more after this
  // cycle's transfer; at most two pixels are ever committed.
  assign credit_used = {1'b0, fifo_level} + {2'b00, inflight_p1};
  assign credit_ok   = credit_used < (3'd2 + {2'b00, xfer});

  assign busy   = (state_q != IDLE);
  assign rd_col = col_q;
  assign rd_row = row_q;

  always_comb begin
    state_d    = state_q;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SCAN;
      end
      SCAN: begin
        rd_en = credit_ok;
        if (credit_ok && col_last && row_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty && !inflight_p1) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0: address issue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rd_en) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // ---- stage p1: read in flight, tags computed at issue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_p1 <= 1'b0;
      sof_p1      <= 1'b0;
      eol_p1      <= 1'b0;
      eof_p1      <= 1'b0;
    end else begin
      inflight_p1 <= rd_en;
      if (rd_en) begin
        sof_p1 <= (col_q == '0) && (row_q == '0);
        eol_p1 <= col_last;
        eof_p1 <= col_last && row_last;
      end
    end
  end

  // ---- stage p2: output skid buffer ----
  pix_skid_fifo #(
    .WIDTH (TW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_frame_raster_reader.sv
// -----------------------------------------------------------------------------
// tb_frame_raster_reader
// Directed bench: a 4x3 instance for timeline, backpressure, restart, reset
// and random-ready scenarios, and a default 320x240 instance for a full frame.
// Memory models return row*16+col (small) and row*1024+col (full) one cycle
// after rd_en, and random data otherwise.
// -----------------------------------------------------------------------------
module tb_frame_raster_reader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_s, ready_s, busy_s, rd_en_s, done_s;
  logic [1:0]  rd_col_s, rd_row_s;
  logic [31:0] rd_data_s, pix_data_s;
  logic        pix_valid_s, pix_sof_s, pix_eol_s, pix_eof_s;

  logic        start_f, ready_f, busy_f, rd_en_f, done_f;
  logic [8:0]  rd_col_f;
  logic [7:0]  rd_row_f;
  logic [31:0] rd_data_f, pix_data_f;
  logic        pix_valid_f, pix_sof_f, pix_eol_f, pix_eof_f;

  frame_raster_reader #(
    .IMG_W(4), .IMG_H(3), .PIX_W(32), .COL_W(2), .ROW_W(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s),
    .rd_en(rd_en_s), .rd_col(rd_col_s), .rd_row(rd_row_s), .rd_data(rd_data_s),
    .pix_data(pix_data_s), .pix_valid(pix_valid_s), .pix_ready(ready_s),
    .pix_sof(pix_sof_s), .pix_eol(pix_eol_s), .pix_eof(pix_eof_s),
    .frame_done(done_s)
  );

  frame_raster_reader u_full (
    .clk(clk), .rst_n(rst_n), .start(start_f), .busy(busy_f),
    .rd_en(rd_en_f), .rd_col(rd_col_f), .rd_row(rd_row_f), .rd_data(rd_data_f),
    .pix_data(pix_data_f), .pix_valid(pix_valid_f), .pix_ready(ready_f),
    .pix_sof(pix_sof_f), .pix_eol(pix_eol_f), .pix_eof(pix_eof_f),
    .frame_done(done_f)
  );

  always @(posedge clk) begin
    rd_data_s <= rd_en_s ? (32'(rd_row_s) * 32'd16 + 32'(rd_col_s)) : $urandom;
    rd_data_f <= rd_en_f ? (32'(rd_row_f) * 32'd1024 + 32'(rd_col_f)) : $urandom;
  end

  int errors = 0;
  int checks = 0;
  int cyc;
  int sb_idx, xfers, sof_n, eol_n, eof_n, done_n;
  logic        prev_v, prev_r;
  logic [31:0] prev_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic st, input logic rdy);
    @(posedge clk);
    #1;
    start_s = st;
    ready_s = rdy;
    cyc++;
    @(negedge clk);
  endtask

  task automatic sb_clear();
    sb_idx = 0; xfers = 0; sof_n = 0; eol_n = 0; eof_n = 0; done_n = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
  endtask

  // Raster-order scoreboard and AXI-style hold check for the 4x3 instance.
  task automatic sb_small();
    int k, r, c;
    if (prev_v && !prev_r) begin
      chk("hold_valid", 32'(pix_valid_s), 32'd1);
      chk("hold_data", pix_data_s, prev_d);
    end
    if (pix_valid_s && ready_s) begin
      k = sb_idx % 12;
      r = k / 4;
      c = k % 4;
      chk("sb_data", pix_data_s, 32'(r * 16 + c));
      chk("sb_sof", 32'(pix_sof_s), 32'(k == 0));
      chk("sb_eol", 32'(pix_eol_s), 32'(c == 3));
      chk("sb_eof", 32'(pix_eof_s), 32'(k == 11));
      sb_idx++;
      xfers++;
      if (pix_sof_s) sof_n++;
      if (pix_eol_s) eol_n++;
      if (pix_eof_s) eof_n++;
    end
    if (done_s) done_n++;
    prev_v = pix_valid_s;
    prev_r = ready_s;
    prev_d = pix_data_s;
  endtask

  initial begin
    int i, j, fbad, fwraps, fx, frames;
    logic [8:0] pc;
    logic [7:0] pr;
    logic have_prev, st, rr;

    rst_n = 1'b0;
    start_s = 1'b0; ready_s = 1'b0;
    start_f = 1'b0; ready_f = 1'b0;
    cyc = 0;

    // ---------------- reset state ----------------
    tick(0, 0);
    tick(0, 0);
    chk("rst_busy", 32'(busy_s), 32'd0);
    chk("rst_rd_en", 32'(rd_en_s), 32'd0);
    chk("rst_addr", {28'd0, rd_row_s, rd_col_s}, 32'd0);
    chk("rst_valid", 32'(pix_valid_s), 32'd0);
    chk("rst_data", pix_data_s, 32'd0);
    chk("rst_tags", {29'd0, pix_eof_s, pix_eol_s, pix_sof_s}, 32'd0);
    chk("rst_done", 32'(done_s), 32'd0);
    chk("rst_full_busy", 32'(busy_f), 32'd0);
    rst_n = 1'b1;
    tick(0, 1);
    tick(0, 1);

    // ---------------- timeline, ready held high ----------------
    sb_clear();
    cyc = -1;
    tick(1, 1);
    sb_small();
    chk("t1_c0_rd_en", 32'(rd_en_s), 32'd0);
    for (int c = 1; c <= 15; c++) begin
      tick(0, 1);
      sb_small();
      i = c - 1;
      j = c - 2;
      chk("t1_rd_en", 32'(rd_en_s), 32'(c >= 1 && c <= 12));
      chk("t1_rd_addr", {28'd0, rd_row_s, rd_col_s},
          (c <= 12) ? 32'((i / 4) * 4 + (i % 4)) : 32'd0);
      chk("t1_valid", 32'(pix_valid_s), 32'(c >= 2 && c <= 13));
      chk("t1_data", pix_data_s,
          (c >= 2 && c <= 13) ? 32'((j / 4) * 16 + (j % 4)) : 32'd0);
      chk("t1_sof", 32'(pix_sof_s), 32'(c == 2));
      chk("t1_eol", 32'(pix_eol_s), 32'(c == 5 || c == 9 || c == 13));
      chk("t1_eof", 32'(pix_eof_s), 32'(c == 13));
      chk("t1_done", 32'(done_s), 32'(c == 14));
      chk("t1_busy", 32'(busy_s), 32'(c >= 1 && c <= 14));
    end
    chk("t1_xfers", 32'(xfers), 32'd12);
    chk("t1_done_n", 32'(done_n), 32'd1);

    // ---------------- backpressure, ready low cycles 4-8 ----------------
    sb_clear();
    cyc = -1;
    tick(1, 1);
    sb_small();
    for (int c = 1; c <= 40; c++) begin
      tick(0, !(c >= 4 && c <= 8));
      sb_small();
      if (c == 4 || c == 9) chk("bp_rd_en_hi", 32'(rd_en_s), 32'd1);
      if (c >= 5 && c <= 8) chk("bp_rd_en_lo", 32'(rd_en_s), 32'd0);
      if (c >= 4 && c <= 8) chk("bp_stall_data", pix_data_s, 32'd2);
      if (done_s) break;
    end
    chk("bp_done_n", 32'(done_n), 32'd1);
    chk("bp_xfers", 32'(xfers), 32'd12);

    // ---------------- start re-pulsed at 3, 14 (ignored) and 15 ----------------
    tick(0, 1);
    sb_clear();
    cyc = -1;
    tick(1, 1);
    sb_small();
    for (int c = 1; c <= 31; c++) begin
      tick(c == 3 || c == 14 || c == 15, 1);
      sb_small();
      if (c == 4)  chk("rs_addr_c4", {28'd0, rd_row_s, rd_col_s}, 32'd3);
      if (c == 14) chk("rs_done_c14", 32'(done_s), 32'd1);
      if (c == 15) chk("rs_idle_c15", {30'd0, busy_s, rd_en_s}, 32'd0);
      if (c == 16) chk("rs_rd_c16", {27'd0, rd_en_s, rd_row_s, rd_col_s}, 32'h10);
      if (c == 29) chk("rs_done_c29", 32'(done_s), 32'd1);
    end
    chk("rs_done_n", 32'(done_n), 32'd2);
    chk("rs_xfers", 32'(xfers), 32'd24);

    // ---------------- asynchronous reset mid-frame ----------------
    sb_clear();
    cyc = -1;
    tick(1, 1);
    sb_small();
    for (int c = 1; c <= 7; c++) begin
      tick(0, 1);
      sb_small();
    end
    chk("ar_rd_en_pre", 32'(rd_en_s), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy_s), 32'd0);
    chk("ar_rd", {27'd0, rd_en_s, rd_row_s, rd_col_s}, 32'd0);
    chk("ar_valid", 32'(pix_valid_s), 32'd0);
    chk("ar_data", pix_data_s, 32'd0);
    chk("ar_tags", {28'd0, done_s, pix_eof_s, pix_eol_s, pix_sof_s}, 32'd0);
    sb_clear();
    tick(0, 1);
    sb_small();
    tick(0, 1);
    sb_small();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(0, 1);
      sb_small();
    end
    chk("ar_no_done", 32'(done_n), 32'd0);
    sb_clear();
    cyc = -1;
    tick(1, 1);
    sb_small();
    for (int c = 1; c <= 40; c++) begin
      tick(0, 1);
      sb_small();
      if (c == 1) chk("ar_restart_addr", {27'd0, rd_en_s, rd_row_s, rd_col_s}, 32'h10);
      if (done_s) break;
    end
    chk("ar_xfers", 32'(xfers), 32'd12);
    chk("ar_done_n", 32'(done_n), 32'd1);

    // ---------------- random ready, 3 back-to-back frames ----------------
    tick(0, 1);
    sb_clear();
    frames = 0;
    for (int c = 0; c < 3000; c++) begin
      st = (!busy_s && !start_s && frames < 3);
      if (st) frames++;
      rr = 1'($urandom_range(0, 1));
      tick(st, rr);
      sb_small();
      if (done_n == 3) break;
    end
    chk("rnd_done_n", 32'(done_n), 32'd3);
    chk("rnd_sof_n", 32'(sof_n), 32'd3);
    chk("rnd_eol_n", 32'(eol_n), 32'd9);
    chk("rnd_eof_n", 32'(eof_n), 32'd3);
    chk("rnd_xfers", 32'(xfers), 32'd36);
    tick(0, 0);

    // ---------------- default 320x240 frame, ready high ----------------
    fbad = 0; fwraps = 0; fx = 0;
    pc = '0; pr = '0; have_prev = 1'b0;
    for (int c = 0; c <= 76803; c++) begin
      @(posedge clk);
      #1;
      start_f = (c == 0);
      ready_f = 1'b1;
      @(negedge clk);
      if (rd_en_f) begin
        if (have_prev && pc == 9'd319) begin
          if (rd_col_f == 9'd0 && rd_row_f == pr + 8'd1) fwraps++;
          else fbad++;
        end
        pc = rd_col_f;
        pr = rd_row_f;
        have_prev = 1'b1;
      end
      if (pix_valid_f && ready_f) begin
        if (pix_data_f !== 32'(fx / 320) * 32'd1024 + 32'(fx % 320)) fbad++;
        fx++;
      end
      if (c == 76800) begin
        chk("full_last_rd_en", 32'(rd_en_f), 32'd1);
        chk("full_last_col", 32'(rd_col_f), 32'd319);
        chk("full_last_row", 32'(rd_row_f), 32'd239);
      end
      if (c == 76801) chk("full_eof", {30'd0, pix_valid_f, pix_eof_f}, 32'd3);
      if (c == 76802) chk("full_done", 32'(done_f), 32'd1);
      if (done_f && c != 76802) fbad++;
    end
    chk("full_xfers", 32'(fx), 32'd76800);
    chk("full_wraps", 32'(fwraps), 32'd239);
    chk("full_order", 32'(fbad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
